stream_checker: RTL
===================

STREAM_CHECKER -- requirements
Module: stream_checker

Interface
REQ-001 Parameter NBITS, default 8, width of stream messages.
REQ-002 Parameter CNT_W, default 16, width of message/error counters.
REQ-003 Parameter TIMEOUT, default 1000, idle cycles in RUN before the check aborts.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse; begins a new check run.
REQ-007 num_msgs  input  CNT_W  expected message count, sampled on start.
REQ-008 ref_val / ref_rdy / ref_msg  input / output / input  1 / 1 / NBITS  expected-message stream (val/rdy).
REQ-009 dut_val / dut_rdy / dut_msg  input / output / input  1 / 1 / NBITS  DUT output stream under check.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  high in DONE when err_count==0 and timeout==0.
REQ-013 timeout  output  1  run ended by TIMEOUT.
REQ-014 msg_count, err_count  output  CNT_W  messages consumed; mismatches seen.
REQ-015 first_err_idx  output  CNT_W; first_err_act, first_err_exp  output  NBITS  index/values of first mismatch.

Function
REQ-016 FSM states IDLE, RUN, DONE; start in any state moves to RUN on the next edge and clears msg_count, err_count, timeout, first_err_* and the expected buffer.
REQ-017 start with num_msgs==0 moves to DONE instead of RUN, with pass=1.
REQ-018 Expected messages are held in a 2-entry FIFO; ref_rdy = !full && !start; ref transfer when ref_val && ref_rdy, in any state.
REQ-019 No bypass: a ref message is comparable no earlier than the cycle after it is accepted.
REQ-020 dut_rdy = (state==RUN) && FIFO not empty; dut transfer when dut_val && dut_rdy; a transfer dequeues the FIFO head in that cycle.
REQ-021 FIFO enqueue and dequeue in the same cycle SHALL both take effect; occupancy unchanged.
REQ-022 On each dut transfer, msg_count increments; if dut_msg != head, err_count increments (saturating at all-ones).
REQ-023 On the first mismatch of a run, first_err_idx = msg_count before increment, first_err_act = dut_msg, first_err_exp = head; later mismatches do not overwrite.
REQ-024 The transfer with msg_count+1 == num_msgs moves RUN to DONE on that edge.
REQ-025 Idle counter resets on every dut transfer and on entry to RUN, increments otherwise in RUN; on reaching TIMEOUT, FSM moves to DONE with timeout=1.
REQ-026 Transfer and timeout in the same cycle: transfer wins, idle counter clears.
REQ-027 DONE holds all outputs stable until start or reset; dut_rdy=0 in IDLE and DONE.
REQ-028 Outputs are registered; pass/done/busy are pure functions of state and registers (no input-to-output paths except ref_rdy via start).

Reset
REQ-029 rst_n low asynchronously forces IDLE, clears FIFO, all counters, timeout, first_err_* to 0; busy=done=pass=0, dut_rdy=0, ref_rdy=1.
REQ-030 Reset mid-run discards the run; no partial result is reported.

Verification
REQ-031 num_msgs=3, ref 0x11,0x22,0x33, dut same values back-to-back -> done after 3rd transfer, pass=1, msg_count=3, err_count=0.
REQ-032 num_msgs=3, dut 0x11,0x2A,0x33 vs ref 0x11,0x22,0x33 -> pass=0, err_count=1, first_err_idx=1, act=0x2A, exp=0x22.
REQ-033 TIMEOUT=10, num_msgs=2, one message only -> done 10 cycles after last transfer, timeout=1, pass=0, msg_count=1.
REQ-034 ref_val held high, dut_val low -> ref_rdy drops after 2 accepts; then dut_val high sustains 1 msg/cycle with concurrent enq/deq.
REQ-035 start with num_msgs=0 -> DONE next cycle, pass=1; start again during RUN -> counters cleared, new run.
REQ-036 rst_n asserted mid-run off-edge -> outputs to reset values immediately; run lost.

Source files
------------

// File: rtl/stream_checker.sv
// Checks a DUT output stream message-by-message against a reference stream.
// Reports pass/fail, message and error counts, the first mismatch, and idle timeout.
module stream_checker #(
    parameter int unsigned NBITS   = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_msgs,
    input  logic             ref_val,
    output logic             ref_rdy,
    input  logic [NBITS-1:0] ref_msg,
    input  logic             dut_val,
    output logic             dut_rdy,
    input  logic [NBITS-1:0] dut_msg,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] msg_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [NBITS-1:0] first_err_act,
    output logic [NBITS-1:0] first_err_exp
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [CNT_W-1:0]  num_exp;
    logic [IDLE_W-1:0] idle_cnt;

    logic [NBITS-1:0]  fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [NBITS-1:0]  head;

    logic              enq;
    logic              dut_xfer;
    logic              mismatch;
    logic              last_msg;
    logic              idle_expired;

    assign fifo_full  = (fifo_cnt == 2'd2);
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign head       = fifo_mem[rd_ptr];

    // Handshakes: start blocks ref intake so the cleared buffer stays empty.
    assign ref_rdy  = !fifo_full && !start;
    assign dut_rdy  = (state_q == ST_RUN) && !fifo_empty;
    assign enq      = ref_val && ref_rdy;
    assign dut_xfer = dut_val && dut_rdy;

    assign mismatch     = (dut_msg != head);
    assign last_msg     = ((msg_count + CNT_W'(1)) == num_exp);
    assign idle_expired = (idle_cnt == IDLE_LAST);

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign pass = done && (err_count == '0) && !timeout;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a transfer takes precedence over an expiring idle counter
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (num_msgs == '0) ? ST_DONE : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (dut_xfer) begin
                        if (last_msg) begin
                            state_d = ST_DONE;
                        end
                    end else if (idle_expired) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Two-entry expected-message buffer; simultaneous enq/deq keeps occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else if (start) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (enq) begin
                fifo_mem[wr_ptr] <= ref_msg;
                wr_ptr           <= ~wr_ptr;
            end
            if (dut_xfer) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({enq, dut_xfer})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Run bookkeeping: counters, first-mismatch capture, idle timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_exp       <= '0;
            idle_cnt      <= '0;
            timeout       <= 1'b0;
            msg_count     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_act <= '0;
            first_err_exp <= '0;
        end else if (start) begin
            num_exp       <= num_msgs;
            idle_cnt      <= '0;
            timeout       <= 1'b0;
            msg_count     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_act <= '0;
            first_err_exp <= '0;
        end else if (state_q == ST_RUN) begin
            if (dut_xfer) begin
                idle_cnt  <= '0;
                msg_count <= msg_count + CNT_W'(1);
                if (mismatch) begin
                    if (err_count != '1) begin
                        err_count <= err_count + CNT_W'(1);
                    end
                    // err_count never returns to zero within a run, so it marks the first miss
                    if (err_count == '0) begin
                        first_err_idx <= msg_count;
                        first_err_act <= dut_msg;
                        first_err_exp <= head;
                    end
                end
            end else if (idle_expired) begin
                timeout <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

endmodule
